// File: rtl/ifetch_seq_ctrl.sv
// Fetch sequencer: walks the fetch PC through I-TLB translation and I-cache access for the instruction buffer.
// Define IFETCH_SAME_PAGE_REDIRECT_EN to let a redirect into the last translated page skip translation.
module ifetch_seq_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                PAGE_BITS = 12,
    parameter int                FETCH_B   = 8,
    parameter int                ID_W      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'hFFFF_FFF0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        redirect_valid_i,
    input  logic [ADDR_W-1:0]           redirect_pc_i,
    input  logic                        ibuf_full_i,
    output logic                        tlb_req_o,
    output logic [ADDR_W-PAGE_BITS-1:0] tlb_vpn_o,
    input  logic                        tlb_ack_i,
    input  logic                        tlb_fault_i,
    output logic                        ic_req_o,
    output logic [ADDR_W-1:0]           ic_addr_o,
    input  logic                        ic_ack_i,
    input  logic                        ic_miss_i,
    input  logic                        ic_fill_done_i,
    output logic                        fetch_not_ready_o,
    output logic [3:0]                  fetch_width_o,
    output logic                        page_bound_o,
    output logic [ID_W-1:0]             fetch_id_o,
    output logic                        fault_valid_o
);

    localparam int                 WB          = PAGE_BITS + 1;
    localparam logic [WB-1:0]      PAGE_SIZE_W = WB'(1 << PAGE_BITS);
    localparam logic [WB-1:0]      FETCH_W     = WB'(FETCH_B);
    localparam logic [WB-1:0]      BOUND_LIM   = WB'((1 << PAGE_BITS) - FETCH_B);

    typedef enum logic [2:0] {ST_RST, ST_XLATE, ST_FETCH, ST_MISS, ST_FAULT} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ID_W-1:0]       id_q, id_d;

    logic [PAGE_BITS-1:0]  off;
    logic                  page_bound;
    logic [WB-1:0]         width;
    logic [ADDR_W-1:0]     pc_inc;
    logic                  page_cross;
    logic                  ic_req;
    logic                  accept;
    logic                  same_page_hit;

    // A fetch never spans a page: near the page end only the bytes up to the boundary are taken.
    assign off        = pc_q[PAGE_BITS-1:0];
    assign page_bound = ({1'b0, off} > BOUND_LIM);
    assign width      = page_bound ? (PAGE_SIZE_W - {1'b0, off}) : FETCH_W;
    assign pc_inc     = pc_q + {{(ADDR_W-WB){1'b0}}, width};
    assign page_cross = (pc_inc[PAGE_BITS-1:0] == '0);

    assign ic_req = (state_q == ST_FETCH) && !ibuf_full_i;
    assign accept = ic_req && ic_ack_i && !redirect_valid_i;

`ifdef IFETCH_SAME_PAGE_REDIRECT_EN
    logic [ADDR_W-PAGE_BITS-1:0] last_vpn_q;
    logic                        last_vpn_vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_vpn_q     <= '0;
            last_vpn_vld_q <= 1'b0;
        end else if (!redirect_valid_i && state_q == ST_XLATE && tlb_ack_i) begin
            if (tlb_fault_i) begin
                last_vpn_vld_q <= 1'b0;
            end else begin
                last_vpn_q     <= pc_q[ADDR_W-1:PAGE_BITS];
                last_vpn_vld_q <= 1'b1;
            end
        end
    end

    assign same_page_hit = last_vpn_vld_q && (redirect_pc_i[ADDR_W-1:PAGE_BITS] == last_vpn_q);
`else
    assign same_page_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            id_q    <= id_d;
        end
    end

    // Redirect overrides everything, abandoning any outstanding miss or fault.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        id_d    = id_q;
        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            id_d    = id_q + ID_W'(1);
            state_d = same_page_hit ? ST_FETCH : ST_XLATE;
        end else begin
            unique case (state_q)
                ST_RST:   state_d = ST_XLATE;
                ST_XLATE: begin
                    if (tlb_ack_i) state_d = tlb_fault_i ? ST_FAULT : ST_FETCH;
                end
                ST_FETCH: begin
                    if (accept) begin
                        pc_d    = pc_inc;
                        id_d    = id_q + ID_W'(1);
                        state_d = page_cross ? ST_XLATE : ST_FETCH;
                    end else if (ic_req && ic_miss_i) begin
                        state_d = ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (ic_fill_done_i) state_d = ST_FETCH;
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_RST;
            endcase
        end
    end

    always_comb begin
        tlb_req_o         = (state_q == ST_XLATE);
        tlb_vpn_o         = pc_q[ADDR_W-1:PAGE_BITS];
        ic_req_o          = ic_req;
        ic_addr_o         = pc_q;
        fetch_not_ready_o = !accept;
        fetch_width_o     = width[3:0];
        page_bound_o      = page_bound;
        fetch_id_o        = id_q;
        fault_valid_o     = (state_q == ST_FAULT);
    end

endmodule

// File: tb/tb_ifetch_seq_ctrl.sv
// Self-checking bench for ifetch_seq_ctrl: a scoreboard of expected accepted fetches plus per-scenario checks.
module tb_ifetch_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        ibuf_full_i;
    logic        tlb_req_o;
    logic [19:0] tlb_vpn_o;
    logic        tlb_ack_i;
    logic        tlb_fault_i;
    logic        ic_req_o;
    logic [31:0] ic_addr_o;
    logic        ic_ack_i;
    logic        ic_miss_i;
    logic        ic_fill_done_i;
    logic        fetch_not_ready_o;
    logic [3:0]  fetch_width_o;
    logic        page_bound_o;
    logic [3:0]  fetch_id_o;
    logic        fault_valid_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [3:0]  width;
        logic        bound;
    } exp_t;

    exp_t sb[$];
    exp_t monE;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    ifetch_seq_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .ibuf_full_i      (ibuf_full_i),
        .tlb_req_o        (tlb_req_o),
        .tlb_vpn_o        (tlb_vpn_o),
        .tlb_ack_i        (tlb_ack_i),
        .tlb_fault_i      (tlb_fault_i),
        .ic_req_o         (ic_req_o),
        .ic_addr_o        (ic_addr_o),
        .ic_ack_i         (ic_ack_i),
        .ic_miss_i        (ic_miss_i),
        .ic_fill_done_i   (ic_fill_done_i),
        .fetch_not_ready_o(fetch_not_ready_o),
        .fetch_width_o    (fetch_width_o),
        .page_bound_o     (page_bound_o),
        .fetch_id_o       (fetch_id_o),
        .fault_valid_o    (fault_valid_o)
    );

    // Every accepted fetch must match the oldest expected entry in the scoreboard.
    always @(negedge clk) begin
        #3;
        if (rst_n === 1'b1 && fetch_not_ready_o === 1'b0) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_accept: addr %h id %0d with nothing expected", ic_addr_o, fetch_id_o);
            end else begin
                monE = sb.pop_front();
                if ({ic_addr_o, fetch_id_o, fetch_width_o, page_bound_o} !== monE) begin
                    errors++;
                    $display("[TB] FAIL accept_data: got addr %h id %0d w %0d pb %b, want addr %h id %0d w %0d pb %b",
                             ic_addr_o, fetch_id_o, fetch_width_o, page_bound_o,
                             monE.addr, monE.id, monE.width, monE.bound);
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    task automatic cyc();
        @(negedge clk);
        redirect_valid_i = 1'b0;
        tlb_ack_i        = 1'b0;
        tlb_fault_i      = 1'b0;
        ic_ack_i         = 1'b0;
        ic_miss_i        = 1'b0;
        ic_fill_done_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; ibuf_full_i = 1'b0;
        tlb_ack_i = 1'b0; tlb_fault_i = 1'b0; ic_ack_i = 1'b0; ic_miss_i = 1'b0; ic_fill_done_i = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (tlb_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_tlb_req: got %b want 0", tlb_req_o); end
        vectors++; if (ic_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ic_req: got %b want 0", ic_req_o); end
        vectors++; if (fetch_not_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_fnr: got %b want 1", fetch_not_ready_o); end
        vectors++; if (fault_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault: got %b want 0", fault_valid_o); end
        vectors++; if (ic_addr_o !== 32'hFFFF_FFF0) begin errors++; $display("[TB] FAIL rst_pc: got %h want FFFFFFF0", ic_addr_o); end
        vectors++; if (fetch_id_o !== 4'd0) begin errors++; $display("[TB] FAIL rst_id: got %0d want 0", fetch_id_o); end
        cyc();
        rst_n = 1'b1;
        #1;
        vectors++; if (tlb_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_state_tlb_req: got %b want 0", tlb_req_o); end
    endtask

    task automatic test_page_cross();
        cyc(); tlb_ack_i = 1'b1; #1;
        vectors++; if (tlb_req_o !== 1'b1) begin errors++; $display("[TB] FAIL first_xlate: got %b want 1", tlb_req_o); end
        vectors++; if (tlb_vpn_o !== 20'hFFFFF) begin errors++; $display("[TB] FAIL first_vpn: got %h want FFFFF", tlb_vpn_o); end
        sb.push_back('{32'hFFFF_FFF0, 4'd0, 4'd8, 1'b0});
        sb.push_back('{32'hFFFF_FFF8, 4'd1, 4'd8, 1'b0});
        sb.push_back('{32'h0000_0000, 4'd2, 4'd8, 1'b0});
        cyc(); ic_ack_i = 1'b1; #1;
        vectors++; if (ic_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fetch_req: got %b want 1", ic_req_o); end
        cyc(); ic_ack_i = 1'b1; #1;
        vectors++; if (ic_addr_o !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL second_addr: got %h want FFFFFFF8", ic_addr_o); end
        cyc(); tlb_ack_i = 1'b1; #1;
        vectors++; if (tlb_req_o !== 1'b1 || ic_req_o !== 1'b0) begin errors++; $display("[TB] FAIL cross_xlate: got tlb %b ic %b want 1 0", tlb_req_o, ic_req_o); end
        vectors++; if (tlb_vpn_o !== 20'h00000) begin errors++; $display("[TB] FAIL cross_vpn: got %h want 00000", tlb_vpn_o); end
        cyc(); ic_ack_i = 1'b1; #1;
        vectors++; if (fetch_id_o !== 4'd2) begin errors++; $display("[TB] FAIL cross_id: got %0d want 2", fetch_id_o); end
        cyc(); #1;
        vectors++; if (ic_addr_o !== 32'h0000_0008 || fetch_id_o !== 4'd3) begin errors++; $display("[TB] FAIL after_cross: got %h/%0d want 00000008/3", ic_addr_o, fetch_id_o); end
        vectors++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL cross_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_page_bound();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_1FFD;
        cyc(); tlb_ack_i = 1'b1; #1;
        vectors++; if (tlb_vpn_o !== 20'h00001 || fetch_id_o !== 4'd4) begin errors++; $display("[TB] FAIL bound_redirect: got vpn %h id %0d want 00001/4", tlb_vpn_o, fetch_id_o); end
        sb.push_back('{32'h0000_1FFD, 4'd4, 4'd3, 1'b1});
        cyc(); ic_ack_i = 1'b1; #1;
        vectors++; if (page_bound_o !== 1'b1 || fetch_width_o !== 4'd3) begin errors++; $display("[TB] FAIL bound_width: got pb %b w %0d want 1/3", page_bound_o, fetch_width_o); end
        cyc(); tlb_ack_i = 1'b1; #1;
        vectors++; if (tlb_req_o !== 1'b1 || tlb_vpn_o !== 20'h00002) begin errors++; $display("[TB] FAIL bound_next_vpn: got %b/%h want 1/00002", tlb_req_o, tlb_vpn_o); end
        vectors++; if (ic_addr_o !== 32'h0000_2000 || fetch_id_o !== 4'd5) begin errors++; $display("[TB] FAIL bound_next_pc: got %h/%0d want 00002000/5", ic_addr_o, fetch_id_o); end
        cyc(); #1;
        vectors++; if (ic_req_o !== 1'b1 || page_bound_o !== 1'b0) begin errors++; $display("[TB] FAIL bound_resume: got req %b pb %b want 1/0", ic_req_o, page_bound_o); end
    endtask

    task automatic test_miss();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        cyc(); tlb_ack_i = 1'b1;
        cyc(); ic_miss_i = 1'b1; #1;
        vectors++; if (ic_req_o !== 1'b1 || ic_addr_o !== 32'h0000_0100) begin errors++; $display("[TB] FAIL miss_req: got %b/%h want 1/00000100", ic_req_o, ic_addr_o); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 9) ic_fill_done_i = 1'b1;
            #1;
            vectors++; if (ic_req_o !== 1'b0 || fetch_id_o !== 4'd6) begin errors++; $display("[TB] FAIL miss_hold: cycle %0d got req %b id %0d want 0/6", i, ic_req_o, fetch_id_o); end
        end
        sb.push_back('{32'h0000_0100, 4'd6, 4'd8, 1'b0});
        sb.push_back('{32'h0000_0108, 4'd7, 4'd8, 1'b0});
        cyc(); ic_ack_i = 1'b1; #1;
        vectors++; if (ic_req_o !== 1'b1 || ic_addr_o !== 32'h0000_0100) begin errors++; $display("[TB] FAIL miss_rereq: got %b/%h want 1/00000100", ic_req_o, ic_addr_o); end
        cyc(); ic_ack_i = 1'b1; ic_miss_i = 1'b1; #1;
        vectors++; if (fetch_not_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL ack_wins: got fnr %b want 0", fetch_not_ready_o); end
        cyc(); #1;
        vectors++; if (ic_req_o !== 1'b1 || ic_addr_o !== 32'h0000_0110 || fetch_id_o !== 4'd8) begin errors++; $display("[TB] FAIL ack_wins_next: got %b/%h/%0d want 1/00000110/8", ic_req_o, ic_addr_o, fetch_id_o); end
    endtask

    task automatic test_fault();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_3000;
        cyc(); tlb_ack_i = 1'b1; tlb_fault_i = 1'b1; #1;
        vectors++; if (tlb_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fault_xlate: got %b want 1", tlb_req_o); end
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            vectors++; if (fault_valid_o !== 1'b1 || ic_req_o !== 1'b0 || tlb_req_o !== 1'b0) begin errors++; $display("[TB] FAIL fault_hold: cycle %0d got fv %b ic %b tlb %b want 1 0 0", i, fault_valid_o, ic_req_o, tlb_req_o); end
        end
        cyc(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_4000;
        cyc(); tlb_ack_i = 1'b1; #1;
        vectors++; if (fault_valid_o !== 1'b0 || tlb_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fault_clear: got fv %b tlb %b want 0 1", fault_valid_o, tlb_req_o); end
        vectors++; if (tlb_vpn_o !== 20'h00004 || fetch_id_o !== 4'd10) begin errors++; $display("[TB] FAIL fault_redirect: got %h/%0d want 00004/10", tlb_vpn_o, fetch_id_o); end
        cyc(); #1;
        vectors++; if (ic_req_o !== 1'b1 || ic_addr_o !== 32'h0000_4000) begin errors++; $display("[TB] FAIL fault_resume: got %b/%h want 1/00004000", ic_req_o, ic_addr_o); end
    endtask

    task automatic test_redirect_ack();
        ic_ack_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_5008; #1;
        vectors++; if (fetch_not_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL redirect_drop: got fnr %b want 1", fetch_not_ready_o); end
        cyc(); tlb_ack_i = 1'b1; #1;
        vectors++; if (ic_addr_o !== 32'h0000_5008 || fetch_id_o !== 4'd11 || tlb_req_o !== 1'b1) begin errors++; $display("[TB] FAIL redirect_pc: got %h/%0d/%b want 00005008/11/1", ic_addr_o, fetch_id_o, tlb_req_o); end
        cyc(); ic_miss_i = 1'b1;
        cyc(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_6000; #1;
        vectors++; if (ic_req_o !== 1'b0) begin errors++; $display("[TB] FAIL redirect_in_miss: got req %b want 0", ic_req_o); end
        cyc(); ic_fill_done_i = 1'b1; #1;
        vectors++; if (tlb_req_o !== 1'b1) begin errors++; $display("[TB] FAIL miss_abandon: got tlb %b want 1", tlb_req_o); end
        cyc(); tlb_ack_i = 1'b1; #1;
        vectors++; if (tlb_req_o !== 1'b1 || fetch_id_o !== 4'd12) begin errors++; $display("[TB] FAIL stale_fill: got tlb %b id %0d want 1/12", tlb_req_o, fetch_id_o); end
        cyc(); #1;
        vectors++; if (ic_req_o !== 1'b1 || ic_addr_o !== 32'h0000_6000) begin errors++; $display("[TB] FAIL redirect_resume: got %b/%h want 1/00006000", ic_req_o, ic_addr_o); end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{32'h0000_6000, 4'd12, 4'd8, 1'b0});
        sb.push_back('{32'h0000_6008, 4'd13, 4'd8, 1'b0});
        for (int i = 0; i < 5; i++) begin
            cyc(); ibuf_full_i = 1'b1; ic_ack_i = 1'b1; #1;
            vectors++; if (ic_req_o !== 1'b0 || fetch_not_ready_o !== 1'b1 || ic_addr_o !== 32'h0000_6000) begin errors++; $display("[TB] FAIL full_hold: cycle %0d got req %b fnr %b addr %h want 0 1 00006000", i, ic_req_o, fetch_not_ready_o, ic_addr_o); end
        end
        cyc(); ibuf_full_i = 1'b0; ic_ack_i = 1'b1; #1;
        vectors++; if (ic_req_o !== 1'b1 || ic_addr_o !== 32'h0000_6000) begin errors++; $display("[TB] FAIL full_resume: got %b/%h want 1/00006000", ic_req_o, ic_addr_o); end
        cyc(); ic_ack_i = 1'b1;
        cyc(); #1;
        vectors++; if (ic_addr_o !== 32'h0000_6010 || fetch_id_o !== 4'd14) begin errors++; $display("[TB] FAIL b2b_pc: got %h/%0d want 00006010/14", ic_addr_o, fetch_id_o); end
        vectors++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain: got %0d pending want 0", sb.size()); end
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_6800;
        cyc(); #1;
`ifdef IFETCH_SAME_PAGE_REDIRECT_EN
        vectors++; if (tlb_req_o !== 1'b0 || ic_req_o !== 1'b1 || ic_addr_o !== 32'h0000_6800) begin errors++; $display("[TB] FAIL same_page: got tlb %b ic %b addr %h want 0 1 00006800", tlb_req_o, ic_req_o, ic_addr_o); end
`else
        vectors++; if (tlb_req_o !== 1'b1 || ic_req_o !== 1'b0 || ic_addr_o !== 32'h0000_6800) begin errors++; $display("[TB] FAIL same_page: got tlb %b ic %b addr %h want 1 0 00006800", tlb_req_o, ic_req_o, ic_addr_o); end
`endif
        vectors++; if (fetch_id_o !== 4'd15) begin errors++; $display("[TB] FAIL id_15: got %0d want 15", fetch_id_o); end
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_7000;
        cyc(); #1;
        vectors++; if (fetch_id_o !== 4'd0 || tlb_req_o !== 1'b1) begin errors++; $display("[TB] FAIL id_wrap: got id %0d tlb %b want 0/1", fetch_id_o, tlb_req_o); end
        cyc(); #1;
        vectors++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL final_drain: got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        $display("[TB] starting ifetch_seq_ctrl bench");
        test_reset();
        test_page_cross();
        test_page_bound();
        test_miss();
        test_fault();
        test_redirect_ack();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
